fifo_uart_tx: RTL and testbench

Serial transmitter that drains the team's synchronous FIFO from its read side. When the FIFO is non-empty and transmission is enabled, the block pops one word, then shifts it out LSB-first on a UART-style line: start bit, data bits, optional parity bit, stop bits. It sits between the FIFO's `RD`/`dataOut`/`EMPTY` port and the chip's serial output pin.

---
 rtl/fifo_uart_tx_pkg.sv | 15 +
 rtl/fifo_uart_tx_baud.sv | 29 ++
 rtl/fifo_uart_tx.sv | 142 ++++++++++++++
 tb/tb_fifo_uart_tx.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_uart_tx_pkg.sv
// Shared types for the FIFO-fed UART transmitter: frame state encoding and line idle level.
package fifo_uart_tx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  localparam logic TX_IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/fifo_uart_tx_baud.sv
// Bit-period timer: bitEnd pulses on the last cycle of every CLKS_PER_BIT-cycle bit period.
module fifo_uart_tx_baud #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic Clk,
  input  logic Rst_n,
  input  logic restart,
  output logic bitEnd
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] r_cnt;

  // restart holds the count at 0 so the first bit period after it is a full one.
  assign bitEnd = !restart && (r_cnt == LAST);

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_cnt <= '0;
    end else if (restart || bitEnd) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/fifo_uart_tx.sv
// Pops words from a synchronous FIFO and shifts them out LSB-first as UART frames.
// Optional even-parity bit is compiled in with `define FIFO_UART_TX_PARITY_EN.
module fifo_uart_tx
  import fifo_uart_tx_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int STOP_BITS    = 1
) (
  input  logic                  Clk,
  input  logic                  Rst_n,
  input  logic                  enable,
  input  logic                  fifoEmpty,
  input  logic [DATA_WIDTH-1:0] fifoData,
  output logic                  fifoRd,
  output logic                  txd,
  output logic                  busy,
  output logic                  txDone,
  output tx_state_t             dbgState
);

  localparam int BW = $clog2(DATA_WIDTH + 1);
  localparam logic [BW-1:0] LAST_DATA = BW'(DATA_WIDTH - 1);
  localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);

  tx_state_t             r_state, w_next;
  logic [DATA_WIDTH-1:0] r_shift, w_shift_next;
  logic [BW-1:0]         r_bit_cnt, w_bit_cnt_next;
  logic                  r_txd, r_busy, r_txdone;
  logic                  w_txd_next, w_restart, w_bit_end;
`ifdef FIFO_UART_TX_PARITY_EN
  logic                  r_parity;
`endif

  fifo_uart_tx_baud #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .Clk    (Clk),
    .Rst_n  (Rst_n),
    .restart(w_restart),
    .bitEnd (w_bit_end)
  );

  always_comb begin
    w_next         = r_state;
    w_shift_next   = r_shift;
    w_bit_cnt_next = r_bit_cnt;
    w_restart      = 1'b0;
    fifoRd         = 1'b0;
    case (r_state)
      IDLE: begin
        w_restart = 1'b1;
        if (enable && !fifoEmpty) begin
          fifoRd = 1'b1;
          w_next = LOAD;
        end
      end
      LOAD: begin
        w_restart      = 1'b1;
        w_shift_next   = fifoData;
        w_bit_cnt_next = '0;
        w_next         = START;
      end
      START: if (w_bit_end) w_next = DATA;
      DATA: begin
        if (w_bit_end) begin
          w_shift_next = r_shift >> 1;
          if (r_bit_cnt == LAST_DATA) begin
            w_bit_cnt_next = '0;
`ifdef FIFO_UART_TX_PARITY_EN
            w_next = PARITY;
`else
            w_next = STOP;
`endif
          end else begin
            w_bit_cnt_next = r_bit_cnt + 1'b1;
          end
        end
      end
`ifdef FIFO_UART_TX_PARITY_EN
      PARITY: if (w_bit_end) w_next = STOP;
`endif
      STOP: begin
        // The bit counter is reused to count stop bits.
        if (w_bit_end) begin
          if (r_bit_cnt == LAST_STOP) begin
            w_bit_cnt_next = '0;
            w_next         = IDLE;
          end else begin
            w_bit_cnt_next = r_bit_cnt + 1'b1;
          end
        end
      end
      default: w_next = IDLE;
    endcase
  end

  // Line level is computed from the next state so the registered txd lines up with r_state.
  always_comb begin
    w_txd_next = TX_IDLE_LEVEL;
    case (w_next)
      START:  w_txd_next = 1'b0;
      DATA:   w_txd_next = w_shift_next[0];
`ifdef FIFO_UART_TX_PARITY_EN
      PARITY: w_txd_next = r_parity;
`endif
      default: w_txd_next = TX_IDLE_LEVEL;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_state   <= IDLE;
      r_shift   <= '0;
      r_bit_cnt <= '0;
      r_txd     <= TX_IDLE_LEVEL;
      r_busy    <= 1'b0;
      r_txdone  <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_shift   <= w_shift_next;
      r_bit_cnt <= w_bit_cnt_next;
      r_txd     <= w_txd_next;
      r_busy    <= (w_next != IDLE);
      r_txdone  <= (r_state == STOP) && (w_next == IDLE);
    end
  end

`ifdef FIFO_UART_TX_PARITY_EN
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_parity <= 1'b0;
    end else if (r_state == LOAD) begin
      r_parity <= ^fifoData;
    end
  end
`endif

  assign txd      = r_txd;
  assign busy     = r_busy;
  assign txDone   = r_txdone;
  assign dbgState = r_state;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed bench for fifo_uart_tx with CLKS_PER_BIT=4, STOP_BITS=1 and a queue-backed FIFO model.
module tb_fifo_uart_tx;
  import fifo_uart_tx_pkg::*;

  localparam int CPB = 4;
`ifdef FIFO_UART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int FRAME = NBITS * CPB;

  logic       Clk = 1'b0;
  logic       Rst_n;
  logic       enable;
  logic       fifoEmpty;
  logic [7:0] fifoData;
  logic       fifoRd, txd, busy, txDone;
  tx_state_t  dbgState;

  fifo_uart_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(CPB), .STOP_BITS(1)) dut (
    .Clk      (Clk),
    .Rst_n    (Rst_n),
    .enable   (enable),
    .fifoEmpty(fifoEmpty),
    .fifoData (fifoData),
    .fifoRd   (fifoRd),
    .txd      (txd),
    .busy     (busy),
    .txDone   (txDone),
    .dbgState (dbgState)
  );

  // Clock and watchdog
  always #5 Clk = ~Clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Vector table: word and its hand-built frame, bit i = line level in bit period i
  typedef struct {
    logic [7:0]  word;
    logic [10:0] frame_par;
    logic [9:0]  frame_plain;
  } vec_t;

  vec_t        vecs[6];
  logic [7:0]  fifo_q[$];
  logic [10:0] exp_q[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;
  int          rd_cyc  = 0;
  logic        rd_seen = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [10:0] frame_of(input int i);
`ifdef FIFO_UART_TX_PARITY_EN
    return vecs[i].frame_par;
`else
    return {1'b0, vecs[i].frame_plain};
`endif
  endfunction

  // Driver: one clock, with the FIFO model popping on a sampled fifoRd
  task automatic cycle();
    @(negedge Clk);
    rd_seen = fifoRd;
    @(posedge Clk);
    cyc++;
    #1;
    if (rd_seen) begin
      rd_cyc = cyc;
      chk("pop_nonempty", (fifo_q.size() > 0), 1);
      if (fifo_q.size() > 0) fifoData = fifo_q.pop_front();
      else fifoData = 8'h00;
      fifoEmpty = (fifo_q.size() == 0);
    end
  endtask

  task automatic push(input logic [7:0] w);
    fifo_q.push_back(w);
    fifoEmpty = 1'b0;
  endtask

  task automatic wait_rd(input int limit, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      cycle();
      if (rd_seen) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Scoreboard: waits for a pop, then checks the frame against the head of exp_q
  task automatic send_check(input string tag);
    logic        ok;
    logic [10:0] exp;
    int          bad;
    exp = exp_q.pop_front();
    wait_rd(200, ok);
    chk({tag, "_rd"}, ok, 1);
    if (!ok) return;
    chk({tag, "_load"}, {busy, txd, txDone}, 3'b110);
    for (int b = 0; b < NBITS; b++) begin
      bad = 0;
      for (int c = 0; c < CPB; c++) begin
        cycle();
        if (txd !== exp[b] || busy !== 1'b1 || txDone !== 1'b0) bad++;
      end
      chk($sformatf("%s_bit%0d_bad_cycles", tag, b), bad, 0);
    end
    cycle();
    chk({tag, "_done"}, {txDone, busy, txd}, 3'b101);
  endtask

  initial begin
    int   bad;
    int   r1;
    int   rds;
    logic done;
    logic ok;

    Rst_n     = 1'b0;
    enable    = 1'b0;
    fifoEmpty = 1'b1;
    fifoData  = 8'h00;

    vecs[0] = '{8'hA5, 11'b1_0_10100101_0, 10'b1_10100101_0};
    vecs[1] = '{8'h07, 11'b1_1_00000111_0, 10'b1_00000111_0};
    vecs[2] = '{8'h3C, 11'b1_0_00111100_0, 10'b1_00111100_0};
    vecs[3] = '{8'hFF, 11'b1_0_11111111_0, 10'b1_11111111_0};
    vecs[4] = '{8'h00, 11'b1_0_00000000_0, 10'b1_00000000_0};
    vecs[5] = '{8'h01, 11'b1_1_00000001_0, 10'b1_00000001_0};

    // Reset state
    repeat (2) @(posedge Clk);
    #1;
    chk("rst_txd", txd, 1);
    chk("rst_busy", busy, 0);
    chk("rst_fifoRd", fifoRd, 0);
    chk("rst_txDone", txDone, 0);
    chk("rst_state", dbgState, IDLE);
    Rst_n = 1'b1;

    // Empty FIFO with enable high: nothing happens for 100 cycles
    enable = 1'b1;
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      cycle();
      if (fifoRd !== 1'b0 || txd !== 1'b1 || busy !== 1'b0) bad++;
    end
    chk("empty_idle_bad_cycles", bad, 0);

    // Table-driven single frames
    for (int i = 0; i < 6; i++) begin
      push(vecs[i].word);
      exp_q.push_back(frame_of(i));
      send_check($sformatf("vec%0d", i));
    end

    // Back-to-back 0x3C then 0xFF: pops exactly FRAME+2 cycles apart
    push(vecs[2].word);
    push(vecs[3].word);
    exp_q.push_back(frame_of(2));
    exp_q.push_back(frame_of(3));
    send_check("b2b0");
    r1 = rd_cyc;
    send_check("b2b1");
    chk("b2b_gap", rd_cyc - r1, FRAME + 2);

    // Enable dropped during data bits: frame completes, no further pop
    push(vecs[2].word);
    push(vecs[0].word);
    wait_rd(200, ok);
    chk("drop_rd", ok, 1);
    repeat (12) cycle();
    chk("drop_busy_mid", busy, 1);
    enable = 1'b0;
    done = 1'b0;
    for (int i = 0; i < 60; i++) begin
      cycle();
      if (txDone === 1'b1) begin
        done = 1'b1;
        break;
      end
    end
    chk("drop_txDone", done, 1);
    rds = 0;
    for (int i = 0; i < 60; i++) begin
      cycle();
      if (rd_seen) rds++;
    end
    chk("drop_no_rd", rds, 0);
    chk("drop_fifo_left", fifo_q.size(), 1);

    // Reset during data bit 3 of the pending 0xA5; next word then goes out normally
    enable = 1'b1;
    wait_rd(20, ok);
    chk("rst_mid_rd", ok, 1);
    repeat (18) cycle();
    chk("rst_mid_pre_txd", {busy, txd}, 2'b10);
    #2;
    Rst_n = 1'b0;
    #1;
    chk("rst_mid_txd", txd, 1);
    chk("rst_mid_busy", busy, 0);
    enable = 1'b0;
    push(vecs[1].word);
    exp_q.push_back(frame_of(1));
    repeat (2) cycle();
    Rst_n  = 1'b1;
    enable = 1'b1;
    send_check("post_rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
